dm_sba_axi_master: RTL and testbench

- Converts the debug module's system-bus-access (SBA) memory port into single-beat AXI4 master transactions. The SBA port is req/gnt/r_valid style, the same interface the debug module drives as master.
- Functionally the reverse of the AXI-to-memory slave bridge on the debug slave path.
- Sits between the debug module master port and the m_axi_dmi_jtag crossbar port.
- Accepts one outstanding request at a time. Returns read data, or a write acknowledge, plus a bus-error flag.

---
 rtl/dm_sba_axi_master.sv | 184 ++++++++++++++++++
 tb/tb_dm_sba_axi_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_axi_master.sv
// Bridges the debug module's SBA req/gnt/r_valid memory port onto single-beat AXI4 master transactions.
// One request is outstanding at a time; completion returns read data or a write acknowledge plus a bus-error flag.
module dm_sba_axi_master #(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 1,
    parameter int XLEN           = 64
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [XLEN-1:0]             addr_i,
    input  logic [XLEN-1:0]             wdata_i,
    input  logic [XLEN/8-1:0]           be_i,
    output logic                        gnt_o,
    output logic                        r_valid_o,
    output logic [XLEN-1:0]             r_rdata_o,
    output logic                        err_o,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awcache,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awqos,
    output logic [3:0]                  m_axi_awregion,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_awuser,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_wuser,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_buser,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic [2:0]                  m_axi_arprot,
    output logic [3:0]                  m_axi_arcache,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arqos,
    output logic [3:0]                  m_axi_arregion,
    output logic [AXI_USER_WIDTH-1:0]   m_axi_aruser,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi_ruser,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam logic [2:0] AXI_SIZE = (XLEN == 64) ? 3'd3 : 3'd2;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP, DONE} state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
    logic [XLEN/8-1:0] be_q;
    logic              aw_done, w_done, err_q;
    logic              grant, aw_hs, w_hs;
    logic              unused_inputs;

    // Grant is held off during reset so nothing is accepted before the FSM is live.
    assign grant = req_i && (state == IDLE) && aresetn;
    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    assign m_axi_awid     = '0;
    assign m_axi_awaddr   = AXI_ADDR_WIDTH'(addr_q);
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = AXI_SIZE;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awcache  = 4'b0010;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_awuser   = '0;
    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = be_q;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_wuser    = '0;
    assign m_axi_arid     = '0;
    assign m_axi_araddr   = AXI_ADDR_WIDTH'(addr_q);
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = AXI_SIZE;
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arcache  = 4'b0010;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_aruser   = '0;
    assign r_rdata_o      = rdata_q;

    assign unused_inputs = ^{m_axi_bid, m_axi_bresp[0], m_axi_buser,
                             m_axi_rid, m_axi_rresp[0], m_axi_rlast, m_axi_ruser};

    // Valids decode straight from registered state, so an async reset drops them at once.
    always_comb begin
        state_next    = state;
        gnt_o         = grant;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        r_valid_o     = 1'b0;
        err_o         = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_next = we_i ? WR : RD;
            end
            WR: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = DONE;
            end
            RD: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = RD_RESP;
            end
            RD_RESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_next = DONE;
            end
            DONE: begin
                r_valid_o  = 1'b1;
                err_o      = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (state == WR_RESP && m_axi_bvalid) err_q <= m_axi_bresp[1];
            if (state == RD_RESP && m_axi_rvalid) begin
                rdata_q <= m_axi_rdata;
                err_q   <= m_axi_rresp[1];
            end
        end
    end

endmodule

// File: tb/tb_dm_sba_axi_master.sv
// Self-checking bench for dm_sba_axi_master: a cycle-stepped AXI slave with per-channel delays,
// table-driven and randomized transactions, checked against a transaction-level expectation model.
module tb_dm_sba_axi_master;

    localparam int IDW = 10;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int UW  = 1;
    localparam int XL  = 64;

    logic            aclk, aresetn;
    logic            req_i, we_i;
    logic [XL-1:0]   addr_i, wdata_i;
    logic [XL/8-1:0] be_i;
    logic            gnt_o, r_valid_o, err_o;
    logic [XL-1:0]   r_rdata_o;
    logic [IDW-1:0]  awid, arid, bid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize, awprot, arprot;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic [3:0]      awcache, arcache, awqos, arqos, awregion, arregion;
    logic            awlock, arlock, awvalid, awready, wvalid, wready, wlast;
    logic            bvalid, bready, arvalid, arready, rvalid, rready, rlast;
    logic [UW-1:0]   awuser, wuser, buser, aruser, ruser;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;

    dm_sba_axi_master #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                        .AXI_USER_WIDTH(UW), .XLEN(XL)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .err_o(err_o),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awprot(awprot), .m_axi_awcache(awcache),
        .m_axi_awlock(awlock), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
        .m_axi_awuser(awuser), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wuser(wuser),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_buser(buser), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arprot(arprot), .m_axi_arcache(arcache),
        .m_axi_arlock(arlock), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
        .m_axi_aruser(aruser), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_ruser(ruser), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
        bit          keep_req;
        bit          chk_lat;
        logic        exp_err;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          pulse_err = 0;
    int          const_err = 0;
    logic        rv_prev = 1'b0;
    logic [63:0] last_rdata = '0;

    // Protocol watchdog: fixed AXI fields, one-cycle completion pulse, never AW and AR together.
    always @(negedge aclk) begin
        if (r_valid_o && rv_prev) pulse_err++;
        rv_prev = r_valid_o;
        if (awvalid && (awlen != 8'd0 || awsize != 3'd3 || awburst != 2'b01 || awcache != 4'b0010 ||
                        awid != '0 || awprot != 3'd0 || awlock || awqos != 4'd0 ||
                        awregion != 4'd0 || awuser != '0)) const_err++;
        if (wvalid && (wlast != 1'b1 || wuser != '0)) const_err++;
        if (arvalid && (arlen != 8'd0 || arsize != 3'd3 || arburst != 2'b01 || arcache != 4'b0010 ||
                        arid != '0 || arprot != 3'd0 || arlock || arqos != 4'd0 ||
                        arregion != 4'd0 || aruser != '0)) const_err++;
        if (awvalid && arvalid) const_err++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                                input logic [7:0] be, input logic [63:0] rd, input logic [1:0] resp,
                                input int awd, input int wdl, input int bd, input int ard,
                                input int rdl, input bit keep, input bit lat, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.be = be; v.rdata = rd; v.resp = resp;
        v.aw_dly = awd; v.w_dly = wdl; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rdl;
        v.keep_req = keep; v.chk_lat = lat; v.exp_err = err;
        return v;
    endfunction

    task automatic clearSlave();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0;
    endtask

    // Runs one SBA transaction end to end while acting as the AXI slave.
    task automatic applyStimulus(input vec_t v, input bit prev_kept);
        int aw_w = v.aw_dly, w_w = v.w_dly, b_w = v.b_dly, ar_w = v.ar_dly, r_w = v.r_dly;
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        int gcyc = -1, vcyc = -1, busy_gnt = 0, unstable = 0;
        bit granted = 0, done = 0, b_pend = 0, r_pend = 0;
        logic [63:0] exp_rdata;
        exp_rdata = v.we ? last_rdata : v.rdata;
        @(posedge aclk); #1;
        req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; be_i = v.be;
        for (int n = 0; n < 300 && !done; n++) begin
            if (n > 0) begin
                @(posedge aclk); #1;
                if (granted && !v.keep_req) req_i = 1'b0;
            end
            awready = awvalid && (aw_w == 0);
            if (awvalid && aw_w > 0) aw_w--;
            wready = wvalid && (w_w == 0);
            if (wvalid && w_w > 0) w_w--;
            arready = arvalid && (ar_w == 0);
            if (arvalid && ar_w > 0) ar_w--;
            bvalid = b_pend && (b_w == 0);
            bresp = v.resp;
            if (b_pend && b_w > 0) b_w--;
            rvalid = r_pend && (r_w == 0);
            rdata = v.rdata; rresp = v.resp;
            if (r_pend && r_w > 0) r_w--;
            @(negedge aclk);
            if (gnt_o) begin
                if (granted) busy_gnt++;
                else begin granted = 1; gcyc = n; end
            end
            if (awvalid && awaddr !== v.addr) unstable++;
            if (wvalid && (wdata !== v.wdata || wstrb !== v.be)) unstable++;
            if (arvalid && araddr !== v.addr) unstable++;
            if (awvalid && awready) aw_cnt++;
            if (wvalid && wready) w_cnt++;
            if (v.we && aw_cnt > 0 && w_cnt > 0 && !b_pend && b_cnt == 0) b_pend = 1;
            if (bvalid && bready) begin b_pend = 0; b_cnt++; end
            if (arvalid && arready) begin ar_cnt++; r_pend = 1; end
            if (rvalid && rready) begin r_pend = 0; r_cnt++; end
            if (r_valid_o) begin
                done = 1; vcyc = n;
                checkOutput("rdata", r_rdata_o, exp_rdata);
                checkOutput("err", err_o, v.exp_err);
            end
        end
        clearSlave();
        checkOutput("completed", done, 1);
        checkOutput("gnt_while_busy", busy_gnt, 0);
        checkOutput("chan_stable", unstable, 0);
        checkOutput("beat_counts", {8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(ar_cnt), 8'(r_cnt)},
                    v.we ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
        if (v.chk_lat) checkOutput("latency", vcyc - gcyc, 3);
        if (prev_kept) checkOutput("b2b_grant_cycle", gcyc, 0);
        if (!v.we) last_rdata = v.rdata;
    endtask

    vec_t tbl[9];

    initial begin
        vec_t rv;
        bit   kept;
        aresetn = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        clearSlave();
        bresp = 2'b00; rresp = 2'b00; rdata = '0; rlast = 1'b1;
        bid = '0; rid = '0; buser = '0; ruser = '0;

        tbl[0] = mk(0, 64'h8000_0010, 64'h0, 8'h00, 64'hDEADBEEF_CAFEF00D, 2'b00, 0,0,0,0,0, 0, 1, 0);
        tbl[1] = mk(1, 64'h8000_0020, 64'h11223344_55667788, 8'h0F, 64'h0, 2'b00, 3,0,0,0,0, 0, 0, 0);
        tbl[2] = mk(1, 64'h0000_1003, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 64'h0, 2'b10, 0,0,0,0,0, 0, 1, 1);
        tbl[3] = mk(0, 64'h4000_0008, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b11, 0,0,0,0,2, 0, 0, 1);
        tbl[4] = mk(1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h7777, 8'h00, 64'h0, 2'b00, 1,2,1,0,0, 0, 0, 0);
        tbl[5] = mk(0, 64'h8000_0100, 64'h0, 8'h00, 64'h55AA_55AA_1234_5678, 2'b00, 0,0,0,10,0, 0, 0, 0);
        tbl[6] = mk(0, 64'h8000_0200, 64'h0, 8'h00, 64'h1111_1111_1111_1111, 2'b00, 0,0,0,0,0, 1, 1, 0);
        tbl[7] = mk(0, 64'h8000_0208, 64'h0, 8'h00, 64'h2222_2222_2222_2222, 2'b00, 0,0,0,0,0, 1, 1, 0);
        tbl[8] = mk(0, 64'h8000_0210, 64'h0, 8'h00, 64'h3333_3333_3333_3333, 2'b00, 0,0,0,0,0, 0, 1, 0);

        #3;
        checkOutput("reset_outputs", {gnt_o, r_valid_o, err_o, awvalid, wvalid, arvalid, bready, rready},
                    8'h00);
        checkOutput("reset_rdata", r_rdata_o, 64'h0);
        @(negedge aclk); @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 9; i++) applyStimulus(tbl[i], (i > 0) ? tbl[i-1].keep_req : 1'b0);

        // Reset while a write is waiting on both AW and W.
        @(posedge aclk); #1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h9000_0000; wdata_i = 64'hBAD; be_i = 8'hFF;
        @(negedge aclk);
        checkOutput("rst_seq_gnt", gnt_o, 1);
        @(posedge aclk); #1;
        @(negedge aclk);
        checkOutput("rst_seq_valids_up", {awvalid, wvalid}, 2'b11);
        #2 aresetn = 1'b0;
        #1;
        checkOutput("rst_async_drop", {awvalid, wvalid, gnt_o, r_valid_o, arvalid}, 5'b0);
        req_i = 1'b0;
        last_rdata = '0;
        @(negedge aclk);
        aresetn = 1'b1;
        checkOutput("rst_rdata_cleared", r_rdata_o, 64'h0);
        applyStimulus(mk(0, 64'h8000_0300, 64'h0, 8'h00, 64'hFEED_FACE_0BAD_BEEF, 2'b00,
                         0,0,0,0,0, 0, 1, 0), 1'b0);

        // Randomized traffic with random slave delays and responses.
        kept = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rv.we = 1'($urandom_range(0, 1));
            rv.addr = {$urandom, $urandom};
            rv.wdata = {$urandom, $urandom};
            rv.be = 8'($urandom);
            rv.rdata = {$urandom, $urandom};
            rv.resp = 2'($urandom_range(0, 3));
            rv.aw_dly = $urandom_range(0, 3); rv.w_dly = $urandom_range(0, 3);
            rv.b_dly = $urandom_range(0, 3); rv.ar_dly = $urandom_range(0, 3);
            rv.r_dly = $urandom_range(0, 3);
            rv.keep_req = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            rv.chk_lat = (rv.aw_dly + rv.w_dly + rv.b_dly + rv.ar_dly + rv.r_dly) == 0;
            rv.exp_err = rv.resp[1];
            applyStimulus(rv, kept);
            kept = rv.keep_req;
        end
        req_i = 1'b0;
        repeat (3) @(negedge aclk);

        checkOutput("rvalid_pulse_width", pulse_err, 0);
        checkOutput("axi_const_fields", const_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
